fm_modulate: RTL

FM_MODULATE -- requirements
Module: fm_modulate

---
 rtl/fm_pkg.sv | 33 +++
 rtl/fm_phase_accum.sv | 66 ++++++
 rtl/fm_modulate.sv | 80 ++++++++
 3 files changed

// File: rtl/fm_pkg.sv
// Shared FM types and widths. The demodulator imports this too, so the output
// word layout {angle, magnitude} is defined in exactly one place.
package fm_pkg;

  localparam int PHASE_W  = 32;
  localparam int SAMPLE_W = 16;
  localparam int ANGLE_W  = 16;
  localparam int MAG_W    = 16;
  localparam int STRB_W   = 4;

  typedef struct packed {
    logic [ANGLE_W-1:0] angle;
    logic [MAG_W-1:0]   mag;
  } fm_word_t;

  typedef struct packed {
    logic [PHASE_W-1:0] inc;
    logic               last;
    logic [STRB_W-1:0]  strb;
  } fm_stage_t;

  // Per-sample phase step: carrier plus the sign-extended audio scaled by the deviation shift.
  function automatic logic [PHASE_W-1:0] fm_increment(
    input logic [SAMPLE_W-1:0] sample,
    input logic [PHASE_W-1:0]  fcw,
    input int unsigned         shift
  );
    logic [PHASE_W-1:0] sext;
    sext = {{(PHASE_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
    return fcw + (sext << shift);
  endfunction

endpackage

// File: rtl/fm_phase_accum.sv
// Stage 2: phase accumulator plus the output register and its ready/valid handshake.
module fm_phase_accum
  import fm_pkg::*;
#(
  parameter logic [MAG_W-1:0] AMPLITUDE = 16'h7FFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  fm_stage_t         in_stage,
  input  logic              out_ready,
  output logic              advance,
  output logic              out_valid,
  output fm_word_t          out_word,
  output logic              out_last,
  output logic [STRB_W-1:0] out_strb
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               valid_q, valid_d;
  fm_word_t           word_q, word_d;
  logic               last_q, last_d;
  logic [STRB_W-1:0]  strb_q, strb_d;

  assign advance = in_valid && (!valid_q || out_ready);

  always_comb begin
    phase_d = phase_q;
    valid_d = valid_q;
    word_d  = word_q;
    last_d  = last_q;
    strb_d  = strb_q;
    if (advance) begin
      // Phase is never cleared by tlast: it runs continuously across packets.
      phase_d = phase_q + in_stage.inc;
      valid_d = 1'b1;
      word_d  = '{angle: phase_d[PHASE_W-1 -: ANGLE_W], mag: AMPLITUDE};
      last_d  = in_stage.last;
      strb_d  = in_stage.strb;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      valid_q <= 1'b0;
      word_q  <= '0;
      last_q  <= 1'b0;
      strb_q  <= '0;
    end else begin
      phase_q <= phase_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      last_q  <= last_d;
      strb_q  <= strb_d;
    end
  end

  assign out_valid = valid_q;
  assign out_word  = word_q;
  assign out_last  = last_q;
  assign out_strb  = strb_q;

endmodule

// File: rtl/fm_modulate.sv
// AXI-Stream FM modulator: audio samples in, {phase angle, constant magnitude} out.
// Two-entry pipeline: stage 1 holds the phase increment, stage 2 accumulates.
module fm_modulate
  import fm_pkg::*;
#(
  parameter int                 C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int                 C_M00_AXIS_TDATA_WIDTH = 32,
  parameter logic [PHASE_W-1:0] CARRIER_FCW            = 32'h0000_0000,
  parameter int unsigned        DEV_SHIFT              = 8,
  parameter logic [MAG_W-1:0]   AMPLITUDE              = 16'h7FFF
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_aresetn,
  input  logic                              s00_axis_tvalid,
  input  logic                              s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic [STRB_W-1:0]                 s00_axis_tstrb,
  output logic                              s00_axis_tready,
  input  logic                              m00_axis_tready,
  output logic                              m00_axis_tvalid,
  output logic                              m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic [STRB_W-1:0]                 m00_axis_tstrb
);

  logic      v1_q, v1_d;
  fm_stage_t s1_q, s1_d;
  logic      adv;
  logic      accept;
  fm_word_t  out_word;
  logic      unused_tdata;

  // Upper half of the input word carries no audio.
  assign unused_tdata = ^s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:SAMPLE_W];

  // Stage 1 can take a new sample whenever it is empty or draining this cycle.
  assign s00_axis_tready = !v1_q || adv;
  assign accept          = s00_axis_tvalid && s00_axis_tready;

  always_comb begin
    v1_d = v1_q;
    s1_d = s1_q;
    if (accept) begin
      v1_d = 1'b1;
      s1_d = '{inc:  fm_increment(s00_axis_tdata[SAMPLE_W-1:0], CARRIER_FCW, DEV_SHIFT),
               last: s00_axis_tlast,
               strb: s00_axis_tstrb};
    end else if (adv) begin
      v1_d = 1'b0;
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      v1_q <= 1'b0;
      s1_q <= '0;
    end else begin
      v1_q <= v1_d;
      s1_q <= s1_d;
    end
  end

  fm_phase_accum #(
    .AMPLITUDE (AMPLITUDE)
  ) u_accum (
    .clk       (s00_axis_aclk),
    .rst_n     (s00_axis_aresetn),
    .in_valid  (v1_q),
    .in_stage  (s1_q),
    .out_ready (m00_axis_tready),
    .advance   (adv),
    .out_valid (m00_axis_tvalid),
    .out_word  (out_word),
    .out_last  (m00_axis_tlast),
    .out_strb  (m00_axis_tstrb)
  );

  assign m00_axis_tdata = C_M00_AXIS_TDATA_WIDTH'(out_word);

endmodule
